// File: rtl/bus_source_encoder.sv
// Registered source-select encoder at the driving end of the 32-source bus.
// The lowest set bit of drive_req wins. A cycle with more than one bit set
// is a conflict; conflicts and spare-source wins are recorded for debug.
module bus_source_encoder #(
   parameter int unsigned N_SRC = 32,
   parameter int unsigned SEL_W = 5,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_SRC-1:0] drive_req,
   input  logic             stall,
   input  logic             clr_err,
   output logic [SEL_W-1:0] sel_out,
   output logic             sel_valid,
   output logic             conflict,
   output logic             conflict_sticky,
   output logic [CNT_W-1:0] conflict_count,
   output logic             spare_err
);

   // Sources at this index and above are spare.
   localparam int unsigned FIRST_SPARE = 24;

   logic [SEL_W-1:0] winner;
   logic             anyReq;
   logic             multiHot;
   logic             spareWin;
   logic             nextSticky;
   logic [CNT_W-1:0] nextCount;
   logic [CNT_W-1:0] baseCount;
   logic             nextSpare;

   // Fixed-priority encoder: scan from the top so the lowest set bit wins.
   always_comb begin
      winner = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (drive_req[N_SRC-1-i]) begin
            winner = SEL_W'(N_SRC-1-i);
         end
      end
   end

   // Request classification; x & (x-1) is nonzero exactly when two or more bits are set.
   always_comb begin
      anyReq   = |drive_req;
      multiHot = |(drive_req & (drive_req - 1'b1));
      spareWin = anyReq && (32'(winner) >= FIRST_SPARE);
   end

   // Debug-record next state: clear first, then apply this cycle's events on top.
   always_comb begin
      baseCount  = clr_err ? '0 : conflict_count;
      nextCount  = baseCount;
      nextSticky = (clr_err ? 1'b0 : conflict_sticky) | (!stall && multiHot);
      nextSpare  = (clr_err ? 1'b0 : spare_err) | (!stall && spareWin);
      if (!stall && multiHot && (baseCount != '1)) begin
         nextCount = baseCount + 1'b1;
      end
   end

   // Select path: sample on enabled cycles, hold select when nothing drives.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_out   <= '0;
         sel_valid <= 1'b0;
         conflict  <= 1'b0;
      end else if (!stall) begin
         if (anyReq) begin
            sel_out <= winner;
         end
         sel_valid <= anyReq;
         conflict  <= multiHot;
      end
   end

   // Debug-record registers; clr_err acts even while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         conflict_sticky <= 1'b0;
         conflict_count  <= '0;
         spare_err       <= 1'b0;
      end else begin
         conflict_sticky <= nextSticky;
         conflict_count  <= nextCount;
         spare_err       <= nextSpare;
      end
   end

endmodule
